// File: rtl/tc_pl_cap_autorange.sv
// tc_pl_cap_autorange
//   Auto-ranging controller for the capture gain chain. Watches the raw ADC
//   stream, picks one of 2**GAIN_W gain codes, drives the gain stage through
//   the gain_value/gain_en/gain_cmpt handshake, waits out analog settling,
//   then measures a peak window and decides whether to step, lock or fail.
//
//   Optional build macro: CAP_AUTORANGE_TRACK_EN
//     defined   -> windows keep being measured in LOCK; a window whose peak
//                  exceeds hi_th (with headroom to step down) re-opens ranging.
//     undefined -> LOCK is static until start or abort.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, abort          run control pulses (abort wins)
//   init_gain             first gain code of each run
//   hi_th, lo_th          peak magnitude thresholds
//   win_len               valid samples per window (0 acts as 1)
//   settle_len            settle cycles after gain_cmpt (0 acts as 1)
//   cmpt_to               gain_cmpt timeout in cycles
//   adc_data, adc_valid   signed sample stream
//   gain_value, gain_en   gain request to the gain stage
//   gain_cmpt             completion pulse from the gain stage
//   busy                  run in progress
//   range_lock, range_err run outcome
//   peak_out              peak magnitude of the last completed window
module tc_pl_cap_autorange #(
  parameter int ADC_W    = 16,
  parameter int GAIN_W   = 2,
  parameter int CNT_W    = 24,
  parameter int MAX_ITER = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [GAIN_W-1:0]       init_gain,
  input  logic [ADC_W-2:0]        hi_th,
  input  logic [ADC_W-2:0]        lo_th,
  input  logic [CNT_W-1:0]        win_len,
  input  logic [CNT_W-1:0]        settle_len,
  input  logic [CNT_W-1:0]        cmpt_to,
  input  logic signed [ADC_W-1:0] adc_data,
  input  logic                    adc_valid,
  output logic [GAIN_W-1:0]       gain_value,
  output logic                    gain_en,
  input  logic                    gain_cmpt,
  output logic                    busy,
  output logic                    range_lock,
  output logic                    range_err,
  output logic [ADC_W-2:0]        peak_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_MEAS   = 3'd4;
  localparam logic [2:0] S_DEC    = 3'd5;
  localparam logic [2:0] S_LOCK   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam int IT_W = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1);
  localparam logic [IT_W-1:0]   IT_MAX   = IT_W'(MAX_ITER);
  localparam logic [IT_W-1:0]   IT_ONE   = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [GAIN_W-1:0] G_ONE    = 1;
  localparam logic [GAIN_W-1:0] G_MAX    = '1;
  localparam logic [ADC_W-2:0]  MAG_ONE  = 1;
  localparam logic [ADC_W-1:0]  ADC_MIN  = {1'b1, {(ADC_W-1){1'b0}}};

  logic [2:0]        state;
  logic [CNT_W-1:0]  tcnt, scnt, wcnt;
  logic [IT_W-1:0]   iter;
  logic [ADC_W-2:0]  peak, neg, mag, peak_nxt;
  logic              win_done, step_dn, step_up, go;

  // |x| fits in ADC_W-1 bits for every x except the most negative code,
  // so the low bits of the two's complement are enough; that code saturates.
  always_comb begin
    neg = ~adc_data[ADC_W-2:0] + MAG_ONE;
    if (adc_data == ADC_MIN)   mag = '1;
    else if (adc_data[ADC_W-1]) mag = neg;
    else                        mag = adc_data[ADC_W-2:0];
  end

  assign peak_nxt = (mag > peak) ? mag : peak;
  // ">=" makes win_len == 0 behave as a one-sample window.
  assign win_done = adc_valid && ((wcnt + CNT_ONE) >= win_len);
  // hi test first so overlapping thresholds resolve toward lower gain.
  assign step_dn  = (peak > hi_th) && (gain_value != '0);
  assign step_up  = (peak < lo_th) && (gain_value != G_MAX);
  assign go       = start && (state == S_IDLE || state == S_LOCK || state == S_ERR);

  assign gain_en  = (state == S_REQ) && !abort;
  assign busy     = !(state == S_IDLE || state == S_LOCK || state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tcnt       <= '0;
      scnt       <= '0;
      wcnt       <= '0;
      iter       <= '0;
      peak       <= '0;
      peak_out   <= '0;
      gain_value <= '0;
      range_lock <= 1'b0;
      range_err  <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      range_lock <= 1'b0;
      range_err  <= 1'b0;
    end else if (go) begin
      state      <= S_REQ;
      gain_value <= init_gain;
      iter       <= '0;
      range_lock <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // completion beats a simultaneous timeout
          if (gain_cmpt) begin
            scnt  <= '0;
            state <= S_SETTLE;
          end else if ((tcnt + CNT_ONE) >= cmpt_to) begin
            range_err <= 1'b1;
            state     <= S_ERR;
          end else begin
            tcnt <= tcnt + CNT_ONE;
          end
        end
        S_SETTLE: begin
          if ((scnt + CNT_ONE) >= settle_len) begin
            peak  <= '0;
            wcnt  <= '0;
            state <= S_MEAS;
          end else begin
            scnt <= scnt + CNT_ONE;
          end
        end
        S_MEAS: begin
          if (adc_valid) begin
            peak <= peak_nxt;
            wcnt <= wcnt + CNT_ONE;
            if (win_done) begin
              peak_out <= peak_nxt;
              state    <= S_DEC;
            end
          end
        end
        S_DEC: begin
          if (step_dn || step_up) begin
            gain_value <= step_dn ? gain_value - G_ONE : gain_value + G_ONE;
            if (iter == IT_MAX) begin
              range_err <= 1'b1;
              state     <= S_ERR;
            end else begin
              iter  <= iter + IT_ONE;
              state <= S_REQ;
            end
          end else begin
            range_lock <= 1'b1;
            peak       <= '0;
            wcnt       <= '0;
            state      <= S_LOCK;
          end
        end
`ifdef CAP_AUTORANGE_TRACK_EN
        S_LOCK: begin
          // keep watching for overload; low-signal windows never step
          if (adc_valid) begin
            peak <= win_done ? '0 : peak_nxt;
            wcnt <= win_done ? '0 : wcnt + CNT_ONE;
            if (win_done) begin
              peak_out <= peak_nxt;
              if ((peak_nxt > hi_th) && (gain_value != '0)) begin
                range_lock <= 1'b0;
                gain_value <= gain_value - G_ONE;
                iter       <= '0;
                state      <= S_REQ;
              end
            end
          end
        end
`else
        S_LOCK: ;
`endif
        S_IDLE, S_ERR: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_pl_cap_autorange.sv
// Directed bench for tc_pl_cap_autorange. Instance u_a uses MAX_ITER=8,
// u_b shares all inputs with MAX_ITER=1 to exercise the iteration limit.
// A responder returns gain_cmpt two cycles after each u_a gain_en.
module tb_tc_pl_cap_autorange;
  logic               clk = 1'b0;
  logic               rst, start, abort, adc_valid, gain_cmpt;
  logic [1:0]         init_gain;
  logic [14:0]        hi_th, lo_th;
  logic [23:0]        win_len, settle_len, cmpt_to;
  logic signed [15:0] adc_data;
  logic [1:0]         gv_a, gv_b;
  logic               en_a, en_b, busy_a, busy_b, lk_a, lk_b, er_a, er_b;
  logic [14:0]        pk_a, pk_b;

  logic signed [15:0] samp_a = 16'sd0, samp_b = 16'sd0;
  logic               ph = 1'b0, cmpt_on = 1'b1;
  int                 en_cnt = 0, total = 0, bad = 0;
  int                 base, n;

  always #5 clk = ~clk;

  tc_pl_cap_autorange #(.MAX_ITER(8)) u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .init_gain(init_gain),
    .hi_th(hi_th), .lo_th(lo_th), .win_len(win_len), .settle_len(settle_len),
    .cmpt_to(cmpt_to), .adc_data(adc_data), .adc_valid(adc_valid),
    .gain_value(gv_a), .gain_en(en_a), .gain_cmpt(gain_cmpt), .busy(busy_a),
    .range_lock(lk_a), .range_err(er_a), .peak_out(pk_a));

  tc_pl_cap_autorange #(.MAX_ITER(1)) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .init_gain(init_gain),
    .hi_th(hi_th), .lo_th(lo_th), .win_len(win_len), .settle_len(settle_len),
    .cmpt_to(cmpt_to), .adc_data(adc_data), .adc_valid(adc_valid),
    .gain_value(gv_b), .gain_en(en_b), .gain_cmpt(gain_cmpt), .busy(busy_b),
    .range_lock(lk_b), .range_err(er_b), .peak_out(pk_b));

  // alternating sample stream
  initial forever begin
    @(posedge clk); #1;
    ph = ~ph;
    adc_data = ph ? samp_a : samp_b;
  end

  always @(negedge clk) if (en_a) en_cnt++;

  // gain stage model: completion two cycles after the request
  initial begin
    gain_cmpt = 1'b0;
    forever begin
      @(negedge clk);
      if (en_a && cmpt_on) begin
        repeat (2) begin @(posedge clk); #1; end
        gain_cmpt = 1'b1;
        @(posedge clk); #1;
        gain_cmpt = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!(lk_a || er_a) && c < 3000) begin tick(); c++; end
    chk({tag, "_no_timeout"}, 32'(c < 3000), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; adc_valid = 1'b1;
    init_gain = 2'd0; hi_th = 15'd30000; lo_th = 15'd3000;
    win_len = 24'd4; settle_len = 24'd2; cmpt_to = 24'd100;
    repeat (3) tick();
    chk("rst_gain", 32'(gv_a), 32'd0);
    chk("rst_en", 32'(en_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_lock", 32'(lk_a), 32'd0);
    chk("rst_err", 32'(er_a), 32'd0);
    chk("rst_peak", 32'(pk_a), 32'd0);
    rst = 1'b0;
    tick();

    // 1: overload steps 3->0, lock at gain 0; u_b hits its iteration limit
    init_gain = 2'd3; samp_a = 16'sd31000; samp_b = -16'sd31000;
    base = en_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_en_lat", 32'(en_a), 32'd1);
    chk("t1_busy", 32'(busy_a), 32'd1);
    wait_done("t1");
    chk("t1_lock", 32'(lk_a), 32'd1);
    chk("t1_err", 32'(er_a), 32'd0);
    chk("t1_gain", 32'(gv_a), 32'd0);
    chk("t1_peak", 32'(pk_a), 32'd31000);
    chk("t1_en_cnt", 32'(en_cnt - base), 32'd4);
    chk("t1_busy_end", 32'(busy_a), 32'd0);
    chk("t5_err", 32'(er_b), 32'd1);
    chk("t5_gain", 32'(gv_b), 32'd1);
    chk("t5_lock", 32'(lk_b), 32'd0);
    tick();

    // 2: small signal steps 0->3, start while busy ignored
    init_gain = 2'd0; samp_a = 16'sd1000; samp_b = -16'sd1000;
    base = en_cnt;
    pulse_start();
    repeat (3) tick();
    init_gain = 2'd2;
    pulse_start();
    wait_done("t2");
    chk("t2_lock", 32'(lk_a), 32'd1);
    chk("t2_gain", 32'(gv_a), 32'd3);
    chk("t2_peak", 32'(pk_a), 32'd1000);
    chk("t2_en_cnt", 32'(en_cnt - base), 32'd4);

    // 3: gain_cmpt never returned
    cmpt_on = 1'b0; init_gain = 2'd1; cmpt_to = 24'd100;
    base = en_cnt;
    pulse_start();
    chk("t3_en", 32'(en_a), 32'd1);
    chk("t3_lock_clr", 32'(lk_a), 32'd0);
    n = 0;
    while (!er_a && n < 300) begin tick(); n++; end
    chk("t3_err_lat", 32'(n), 32'd101);
    chk("t3_err", 32'(er_a), 32'd1);
    chk("t3_busy", 32'(busy_a), 32'd0);
    repeat (20) tick();
    chk("t3_en_cnt", 32'(en_cnt - base), 32'd1);
    chk("t3_gain", 32'(gv_a), 32'd1);
    cmpt_on = 1'b1;

    // 4: most negative code saturates
    init_gain = 2'd0; samp_a = 16'sh8000; samp_b = 16'sd100;
    pulse_start();
    wait_done("t4");
    chk("t4_lock", 32'(lk_a), 32'd1);
    chk("t4_peak", 32'(pk_a), 32'h7FFF);
    chk("t4_gain", 32'(gv_a), 32'd0);

    // 6: abort in SETTLE, then immediate restart; settle latency check
    init_gain = 2'd3; samp_a = 16'sd1000; samp_b = -16'sd1000;
    settle_len = 24'd10; win_len = 24'd1;
    pulse_start();
    n = 0;
    while (!gain_cmpt && n < 50) begin tick(); n++; end
    chk("t6_cmpt_seen", 32'(gain_cmpt), 32'd1);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_busy", 32'(busy_a), 32'd0);
    chk("t6_en_idle", 32'(en_a), 32'd0);
    chk("t6_lock", 32'(lk_a), 32'd0);
    base = en_cnt;
    pulse_start();
    chk("t6_restart_en", 32'(en_a), 32'd1);
    n = 0;
    while (!gain_cmpt && n < 50) begin tick(); n++; end
    n = 0;
    while (!lk_a && n < 100) begin tick(); n++; end
    chk("t6_settle_lat", 32'(n), 32'd13);
    chk("t6_gain", 32'(gv_a), 32'd3);
    chk("t6_en_cnt", 32'(en_cnt - base), 32'd1);

    // overload after lock
    samp_a = 16'sd32000; samp_b = -16'sd32000;
    base = en_cnt;
`ifdef CAP_AUTORANGE_TRACK_EN
    n = 0;
    while (!en_a && n < 50) begin tick(); n++; end
    chk("trk_en", 32'(en_a), 32'd1);
    chk("trk_lock", 32'(lk_a), 32'd0);
    chk("trk_gain", 32'(gv_a), 32'd2);
    chk("trk_en_cnt", 32'(en_cnt - base), 32'd1);
`else
    repeat (20) tick();
    chk("lock_static", 32'(lk_a), 32'd1);
    chk("lock_gain", 32'(gv_a), 32'd3);
    chk("lock_en_cnt", 32'(en_cnt - base), 32'd0);
`endif

    // reset mid-run
    pulse_start();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy_a), 32'd0);
    chk("rst_mid_gain", 32'(gv_a), 32'd0);
    chk("rst_mid_peak", 32'(pk_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
